// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: register offsets, FSM states and field constants shared by the UART TX block
package apb_uart_pkg;

    localparam logic [3:0] TXDATA_OFS  = 4'h0;
    localparam logic [3:0] STATUS_OFS  = 4'h4;
    localparam logic [3:0] BAUDDIV_OFS = 4'h8;
    localparam logic [3:0] CTRL_OFS    = 4'hC;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVR   = 3;
    localparam int ST_CNT   = 4;

    localparam logic [1:0] CTRL_RST = 2'b01;

endpackage

// File: rtl/apb_uart_tx_sync_fifo.sv
// sync_fifo: first-word-fall-through byte FIFO with full/empty/count flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // pointers and occupancy; a reset flushes the queue
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage needs no reset; only slots behind the write pointer are ever read
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB completer with register file, TX FIFO, baud divider and 8N1 frame FSM
module apb_uart_tx
    import apb_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STROBE_WIDTH = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int DIV_WIDTH    = 16,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [STROBE_WIDTH-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    TXD,
    output logic                    tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] baud_q, baud_d, div_q, div_d, cnt_q, cnt_d, eff_div;
    logic [1:0]           ctrl_q, ctrl_d;
    logic                 ovr_q, ovr_d, irq_q;
    logic [7:0]           shift_q, shift_d, fifo_rdata;
    logic [2:0]           bit_q, bit_d;
    logic [CW-1:0]        count;
    logic                 full, empty, busy, pop, push, push_req, ovr_set;
    logic                 access, wr, rd, valid_ofs, tick, load;
    logic [3:0]           ofs;
    logic                 unused_bits;

    assign unused_bits = ^{PPROT, PADDR, PWDATA, PSTRB};

    assign access    = PSEL & PENABLE;
    assign wr        = access & PWRITE;
    assign rd        = access & ~PWRITE;
    assign ofs       = PADDR[3:0];
    assign valid_ofs = ofs == TXDATA_OFS || ofs == STATUS_OFS || ofs == BAUDDIV_OFS || ofs == CTRL_OFS;
    assign push_req  = wr & (ofs == TXDATA_OFS) & PSTRB[0];
    assign push      = push_req & ~full;
    assign ovr_set   = push_req & full;
    assign busy      = state_q != IDLE;

    assign PREADY  = access;
    assign PSLVERR = access & (~valid_ofs | ovr_set);
    assign PRDATA  = !rd                 ? '0 :
                     ofs == STATUS_OFS  ? DATA_WIDTH'({count, ovr_q, busy, empty, full}) :
                     ofs == BAUDDIV_OFS ? DATA_WIDTH'(baud_q) :
                     ofs == CTRL_OFS    ? DATA_WIDTH'(ctrl_q) : '0;

    assign TXD    = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    assign tx_irq = irq_q;

    assign eff_div = baud_q == '0 ? DIV_WIDTH'(1) : baud_q;
    assign tick    = cnt_q == div_q - 1'b1;
    assign load    = ctrl_q[0] & ~empty & (state_q == IDLE | (state_q == STOP & tick));
    assign pop     = load;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (PCLK),
        .rstn_i  (PRESETn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (PWDATA[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // register file updates from committed APB writes; overrun is sticky until written 1
    always_comb begin
        baud_d = baud_q;
        ctrl_d = ctrl_q;
        ovr_d  = ovr_q | ovr_set;
        if (wr && ofs == BAUDDIV_OFS)
            for (int b = 0; b < DIV_WIDTH; b++)
                if (PSTRB[b/8]) baud_d[b] = PWDATA[b];
        if (wr && ofs == CTRL_OFS && PSTRB[0]) ctrl_d = PWDATA[1:0];
        if (wr && ofs == STATUS_OFS && PWDATA[ST_OVR]) ovr_d = 1'b0;
    end

    // frame sequencing: each symbol holds for div_q cycles, a new frame loads from IDLE or end of STOP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
        case (state_q)
            IDLE:  cnt_d = '0;
            START: if (tick) begin
                       cnt_d   = '0;
                       state_d = DATA;
                   end
            DATA:  if (tick) begin
                       cnt_d   = '0;
                       shift_d = shift_q >> 1;
                       bit_d   = bit_q + 3'd1;
                       if (bit_q == 3'd7) state_d = STOP;
                   end
            STOP:  if (tick) begin
                       cnt_d   = '0;
                       state_d = IDLE;
                   end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = START;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = fifo_rdata;
            div_d   = eff_div;
        end
    end

    // state and register flops; reset aborts any frame in flight
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            div_q   <= DEFAULT_DIV;
            baud_q  <= DEFAULT_DIV;
            ctrl_q  <= CTRL_RST;
            ovr_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            baud_q  <= baud_d;
            ctrl_q  <= ctrl_d;
            ovr_q   <= ovr_d;
            irq_q   <= ctrl_q[1] & empty & ~busy;
        end
    end

endmodule

// File: tb/tb_apb_uart_tx.sv
// tb_apb_uart_tx: register vector table, frame reference model and multi-cycle corner sequences
module tb_apb_uart_tx;

    logic        PCLK = 1'b0, PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0, PRDATA;
    logic [3:0]  PSTRB = '0;
    logic [2:0]  PPROT = '0;
    logic        PREADY, PSLVERR, TXD, tx_irq;

    int checks = 0, errors = 0;

    typedef logic [7:0] byte_q_t [$];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        e;
        logic [31:0] r;
        string       n;
    } vec_t;

    vec_t tbl [$];

    apb_uart_tx dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .TXD(TXD), .tx_irq(tx_irq)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic e, input logic [31:0] r, input string n);
        mk.w = w; mk.a = a; mk.d = d; mk.s = s; mk.e = e; mk.r = r; mk.n = n;
    endfunction

    function automatic logic [31:0] status_exp(input int n, input logic ovr, input logic busy);
        return (32'(n) << 4) | (32'(ovr) << 3) | (32'(busy) << 2) | (32'(n == 0) << 1) | 32'(n == 8);
    endfunction

    // one APB transfer, entered and left 1ns after a rising edge; write commits at the final edge
    task automatic apb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rdata, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #3;
        rdata = PRDATA;
        err = PSLVERR;
        check("pready", 32'(PREADY), 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic e, input string n);
        logic [31:0] r;
        logic err;
        apb(1'b1, a, d, s, r, err);
        check({n, " pslverr"}, 32'(err), 32'(e));
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string n);
        logic [31:0] r;
        logic err;
        apb(1'b0, a, 32'h0, 4'h0, r, err);
        check({n, " prdata"}, r, exp);
        check({n, " pslverr"}, 32'(err), 32'd0);
    endtask

    // reference line model: every byte is 10 symbols (start, 8 data LSB first, stop) of div cycles each
    task automatic check_frames(input byte_q_t bytes, input int div);
        int total, f, s;
        logic exp;
        total = 10 * div * bytes.size();
        for (int k = 0; k < total; k++) begin
            @(posedge PCLK); #1;
            f = k / (10 * div);
            s = (k % (10 * div)) / div;
            exp = s == 0 ? 1'b0 : s == 9 ? 1'b1 : bytes[f][s-1];
            check($sformatf("txd frame%0d sym%0d cyc%0d", f, s, k), 32'(TXD), 32'(exp));
        end
        @(posedge PCLK); #1;
        check("txd idle after frames", 32'(TXD), 32'd1);
    endtask

    initial begin
        byte_q_t q;
        logic [31:0] r;
        logic err;
        int n, div;

        repeat (3) @(posedge PCLK);
        #1;
        check("reset txd", 32'(TXD), 32'd1);
        check("reset irq", 32'(tx_irq), 32'd0);
        check("reset pslverr", 32'(PSLVERR), 32'd0);
        check("reset prdata", PRDATA, 32'd0);
        PRESETn = 1'b1;
        rd(32'h4, 32'h2, "reset status");
        rd(32'h8, 32'h10, "reset bauddiv");
        rd(32'hC, 32'h1, "reset ctrl");

        tbl.push_back(mk(1, 32'hC, 32'h0,    4'b0001, 0, 0,         "ctrl clear"));
        tbl.push_back(mk(0, 32'hC, 0,        0,       0, 32'h0,     "ctrl rd0"));
        tbl.push_back(mk(1, 32'h8, 32'h1234, 4'b0011, 0, 0,         "baud wr"));
        tbl.push_back(mk(0, 32'h8, 0,        0,       0, 32'h1234,  "baud rd"));
        tbl.push_back(mk(1, 32'h8, 32'hABCD, 4'b0010, 0, 0,         "baud byte1"));
        tbl.push_back(mk(0, 32'h8, 0,        0,       0, 32'hAB34,  "baud rd strb"));
        tbl.push_back(mk(1, 32'hC, 32'h3,    4'b1110, 0, 0,         "ctrl no strb0"));
        tbl.push_back(mk(0, 32'hC, 0,        0,       0, 32'h0,     "ctrl unchanged"));
        tbl.push_back(mk(1, 32'h2, 32'hFF,   4'b1111, 1, 0,         "bad ofs wr"));
        tbl.push_back(mk(0, 32'hE, 0,        0,       1, 32'h0,     "bad ofs rd"));
        tbl.push_back(mk(0, 32'h0, 0,        0,       0, 32'h0,     "txdata rd"));
        tbl.push_back(mk(1, 32'h0, 32'h55,   4'b0000, 0, 0,         "txdata no strb"));
        tbl.push_back(mk(0, 32'h4, 0,        0,       0, 32'h2,     "status no push"));
        tbl.push_back(mk(1, 32'h8, 32'h4,    4'b1111, 0, 0,         "baud 4"));
        tbl.push_back(mk(1, 32'hC, 32'h1,    4'b0001, 0, 0,         "ctrl txen"));
        tbl.push_back(mk(0, 32'hC, 0,        0,       0, 32'h1,     "ctrl rd1"));
        foreach (tbl[i]) begin
            apb(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, r, err);
            check({tbl[i].n, " pslverr"}, 32'(err), 32'(tbl[i].e));
            if (!tbl[i].w) check({tbl[i].n, " prdata"}, r, tbl[i].r);
        end

        // single frame 0xA5 at div 4, start bit on the edge after the commit
        wr(32'h0, 32'hA5, 4'h1, 0, "push a5");
        q = '{8'hA5};
        check_frames(q, 4);

        // three queued bytes released by tx_en: back-to-back frames
        wr(32'hC, 32'h0, 4'h1, 0, "ctrl off");
        wr(32'h8, 32'h2, 4'hF, 0, "baud 2");
        q = {};
        for (int i = 0; i < 3; i++) begin
            q.push_back(8'($urandom));
            wr(32'h0, 32'(q[i]), 4'h1, 0, "push3");
        end
        rd(32'h4, status_exp(3, 0, 0), "status 3 queued");
        wr(32'hC, 32'h1, 4'h1, 0, "ctrl on");
        check_frames(q, 2);
        rd(32'h4, 32'h2, "status after burst");

        // interrupt: high when idle and empty, low for the whole frame, back one edge after IDLE
        wr(32'h8, 32'h1, 4'hF, 0, "baud 1");
        wr(32'hC, 32'h3, 4'h1, 0, "ctrl irq");
        wr(32'h0, 32'h3C, 4'h1, 0, "push irq byte");
        check("irq at commit", 32'(tx_irq), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge PCLK); #1;
            check($sformatf("irq edge%0d", k), 32'(tx_irq), 32'(k >= 12));
        end

        // overrun: ninth push with tx disabled is refused and flagged
        wr(32'hC, 32'h0, 4'h1, 0, "ctrl off2");
        q = {};
        for (int i = 0; i < 9; i++) begin
            wr(32'h0, 32'(i), 4'h1, q.size() == 8, $sformatf("fill%0d", i));
            if (q.size() < 8) q.push_back(8'(i));
        end
        rd(32'h4, status_exp(q.size(), 1, 0), "status overrun");
        wr(32'h4, 32'hF7, 4'hF, 0, "status no clear");
        rd(32'h4, status_exp(q.size(), 1, 0), "overrun sticky");
        wr(32'h4, 32'h8, 4'hF, 0, "status clear");
        rd(32'h4, status_exp(q.size(), 0, 0), "overrun cleared");

        // reset in the middle of a data bit aborts the frame and flushes the FIFO
        wr(32'h8, 32'h5, 4'hF, 0, "baud 5");
        wr(32'hC, 32'h3, 4'h1, 0, "ctrl on2");
        rd(32'h4, status_exp(7, 0, 1), "status busy");
        repeat (5) @(posedge PCLK);
        #1;
        check("txd mid data bit", 32'(TXD), 32'(q[0][1]));
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        check("mid reset txd", 32'(TXD), 32'd1);
        check("mid reset irq", 32'(tx_irq), 32'd0);
        PRESETn = 1'b1;
        rd(32'h4, 32'h2, "mid reset status");
        rd(32'h8, 32'h10, "mid reset baud");

        // random byte bursts at random divisors, including divisor 0 treated as 1
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(0, 3);
            n = $urandom_range(1, 4);
            wr(32'hC, 32'h0, 4'h1, 0, "rnd ctrl off");
            wr(32'h8, 32'(div), 4'hF, 0, "rnd baud");
            q = {};
            for (int i = 0; i < n; i++) begin
                q.push_back(8'($urandom));
                wr(32'h0, 32'(q[i]), 4'h1, 0, "rnd push");
            end
            wr(32'hC, 32'h1, 4'h1, 0, "rnd ctrl on");
            check_frames(q, div == 0 ? 1 : div);
            rd(32'h4, 32'h2, "rnd status idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
